b2g_stream: RTL and testbench

//  Streaming binary-to-Gray encoder, the transmit-side counterpart of the Gray-to-binary converters.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_skid_buf.sv | 57 +++++
 rtl/b2g_stream.sv | 91 +++++++++
 tb/tb_b2g_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared code-converter definitions used by the binary-to-Gray and
// Gray-to-binary paths.
package conv_pkg;

    localparam int CONV_W_DEFAULT = 4;
    localparam int CONV_W_MAX     = 32;

    // Gray encode; narrower words are zero-extended so the shifted-in bit is 0
    function automatic logic [CONV_W_MAX-1:0] bin2gray(input logic [CONV_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/conv_skid_buf.sv
// Two-entry valid/ready skid buffer. The head register drives the output;
// the tail register absorbs the word accepted while the upstream ready is
// still catching up with downstream backpressure.
module conv_skid_buf #(
    parameter int DW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic          r_head_v;
    logic          r_tail_v;

    // Occupancy update; a push while both entries are held is dropped
    // because the source side never issues one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
        end else if (r_tail_v) begin
            if (i_pop) begin
                r_head   <= r_tail;
                r_tail_v <= 1'b0;
            end
        end else if (r_head_v) begin
            if (i_push && i_pop) begin
                r_head <= i_data;
            end else if (i_push) begin
                r_tail   <= i_data;
                r_tail_v <= 1'b1;
            end else if (i_pop) begin
                r_head_v <= 1'b0;
            end
        end else if (i_push) begin
            r_head   <= i_data;
            r_head_v <= 1'b1;
        end
    end

    // Head drives the output; tail valid implies head valid
    always_comb begin
        o_valid = r_head_v;
        o_data  = r_head;
        o_count = {r_tail_v, r_head_v & ~r_tail_v};
    end

endmodule

// File: rtl/b2g_stream.sv
// Streaming binary-to-Gray encoder. Words come from the external stream or
// from an internal free-running counter, are Gray-encoded before buffering,
// and leave through a 2-entry skid buffer together with a wrap marker.
module b2g_stream
    import conv_pkg::*;
#(
    parameter int WIDTH = CONV_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_src_sel,
    input  logic             i_cnt_clr,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_bin_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_gray_out,
    output logic             o_out_last
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_in_ready;

    logic             w_push_ext;
    logic             w_push_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_space;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_gray;
    logic             w_last;
    logic [1:0]       w_count;
    logic [1:0]       w_count_nxt;
    logic [WIDTH:0]   w_buf_data;

    // Source selection, encoding and next-occupancy prediction
    always_comb begin
        w_space     = (w_count != 2'd2);
        w_push_ext  = ~i_src_sel & i_in_valid & r_in_ready;
        w_push_cnt  = i_src_sel & w_space;
        w_push      = w_push_ext | w_push_cnt;
        w_pop       = o_out_valid & i_out_ready;
        w_bin       = i_src_sel ? r_cnt : i_bin_in;
        w_gray      = WIDTH'(bin2gray(CONV_W_MAX'(w_bin)));
        w_last      = i_src_sel & (r_cnt == {WIDTH{1'b1}});
        w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};
    end

    // Counter advances only when its value is enqueued; clear wins but the
    // pre-clear value is what gets enqueued in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_push_cnt) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered ready: open while at most one entry remains after this cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= ~i_src_sel & (w_count_nxt <= 2'd1);
        end
    end

    conv_skid_buf #(
        .DW (WIDTH + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  ({w_last, w_gray}),
        .i_pop   (w_pop),
        .o_valid (o_out_valid),
        .o_data  (w_buf_data),
        .o_count (w_count)
    );

    // Output unpacking
    always_comb begin
        o_in_ready = r_in_ready;
        o_gray_out = w_buf_data[WIDTH-1:0];
        o_out_last = w_buf_data[WIDTH];
    end

endmodule

// File: tb/tb_b2g_stream.sv
// Scoreboard bench for b2g_stream: a reference model predicts every
// enqueued word from the stream rules; a monitor compares the output head.
module tb_b2g_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         src_sel = 1'b0;
    logic         cnt_clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] bin_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] gray_out;
    logic         out_last;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] g;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   occ = 0;
    int   cnt = 0;
    logic exp_ir = 1'b0;

    always #5 clk = ~clk;

    b2g_stream #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_src_sel   (src_sel),
        .i_cnt_clr   (cnt_clr),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_bin_in    (bin_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_gray_out  (gray_out),
        .o_out_last  (out_last)
    );

    function automatic logic [W-1:0] gray_of(input int b);
        int v;
        v = b % (1 << W);
        return W'(v ^ (v >> 1));
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts handshakes at mid-cycle from the stream rules
    always @(negedge clk) begin
        if (rst) begin
            occ    = 0;
            cnt    = 0;
            exp_ir = 1'b0;
            sb.delete();
        end else begin
            bit enq_ext, enq_cnt, deq;
            check("in_ready", int'(in_ready), int'(exp_ir));
            check("out_valid", int'(out_valid), int'(occ > 0));
            enq_ext = !src_sel && in_valid && exp_ir;
            enq_cnt = src_sel && (occ < 2);
            deq     = (occ > 0) && out_ready;
            if (enq_ext) sb.push_back('{g: gray_of(int'(bin_in)), last: 1'b0});
            if (enq_cnt) sb.push_back('{g: gray_of(cnt), last: (cnt == (1 << W) - 1)});
            occ    = occ + int'(enq_ext || enq_cnt) - int'(deq);
            exp_ir = !src_sel && (occ <= 1);
            if (cnt_clr) cnt = 0;
            else if (enq_cnt) cnt = (cnt + 1) % (1 << W);
        end
    end

    // Monitor: whenever a word is presented it must match the queue head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %b expected none at %0t", gray_out, $time);
            end else begin
                check("gray_out", int'(gray_out), int'(sb[0].g));
                check("out_last", int'(out_last), int'(sb[0].last));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] words [5];
        words[0] = 4'b0100; words[1] = 4'b0111; words[2] = 4'b1001;
        words[3] = 4'b1101; words[4] = 4'b1111;

        // reset values
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_gray_out", int'(gray_out), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("in_ready_after_release", int'(in_ready), 1);

        // directed external stream, back-to-back
        foreach (words[i]) begin
            in_valid = 1'b1;
            bin_in   = words[i];
            tick();
        end
        in_valid = 1'b0;
        check("stream_first_latency", int'(out_valid), 1);
        tick();
        tick();

        // backpressure for 3 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            bin_in   = W'($urandom);
            tick();
        end
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // counter mode, free flowing: two full wraps
        src_sel = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        // counter mode with random backpressure
        for (int i = 0; i < 150; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // clear coinciding with the enqueue of 0101
        out_ready = 1'b1;
        src_sel   = 1'b0;
        rst       = 1'b1;
        tick();
        rst     = 1'b0;
        src_sel = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // mixed random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 23 == 0) src_sel = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            bin_in    = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        cnt_clr  = 1'b0;
        in_valid = 1'b0;

        // reset with two words buffered
        src_sel   = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_full", int'(out_valid), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_gray_out", int'(gray_out), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // drain
        src_sel  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
